// File: rtl/gmii_fifo_writer.sv
// GMII receive front end: packs {en, er, data} words into the passthrough FIFO
// with frame admission, guaranteed inter-frame gap, idle compression and overflow truncation.
module gmii_fifo_writer #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [7:0]  START_MAX  = 8'd200,
  parameter logic [7:0]  FULL_MARK  = 8'd252,
  parameter logic [7:0]  MIN_FILL   = 8'd4,
  parameter logic [3:0]  IFG_MIN    = 4'd12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gmii_rx_dv,
  input  logic                  gmii_rx_er,
  input  logic [DATA_WIDTH-1:0] gmii_rxd,
  input  logic [7:0]            usedw,
  output logic                  wrreq,
  output logic [DATA_WIDTH+1:0] FIFO_wrdata,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           trunc_cnt
);

  localparam logic [7:0] GUARD_LVL = 8'd254;

  typedef enum logic [1:0] {IDLE, PASS, DROP, IFG} state_t;

  state_t                state_q, state_d;
  logic                  dv_prev_q;
  logic [3:0]            ifg_cnt_q, ifg_cnt_d;
  logic                  trunc_flag_q, trunc_flag_d;
  logic                  wrreq_q, wrreq_d;
  logic [DATA_WIDTH+1:0] data_q, data_d;
  logic [15:0]           drop_q, drop_d;
  logic [15:0]           trunc_q, trunc_d;

  logic                  start;
  logic                  idle_ok;
  logic                  want;
  logic [DATA_WIDTH+1:0] word;

  assign start   = gmii_rx_dv & ~dv_prev_q;
  assign idle_ok = (usedw < MIN_FILL);

  always_comb begin
    state_d      = state_q;
    ifg_cnt_d    = ifg_cnt_q;
    trunc_flag_d = trunc_flag_q;
    drop_d       = drop_q;
    trunc_d      = trunc_q;
    want         = 1'b0;
    word         = '0;
    case (state_q)
      IDLE, IFG: begin
        if (start) begin
          if (usedw <= START_MAX) begin
            state_d = PASS;
            want    = 1'b1;
            word    = {1'b1, gmii_rx_er, gmii_rxd};
          end else begin
            state_d      = DROP;
            trunc_flag_d = 1'b0;
            drop_d       = drop_q + 16'd1;
          end
        end else if (state_q == IFG) begin
          want      = 1'b1;
          ifg_cnt_d = ifg_cnt_q - 4'd1;
          if (ifg_cnt_q <= 4'd1) state_d = IDLE;
        end else begin
          want = idle_ok;
        end
      end
      PASS: begin
        if (gmii_rx_dv) begin
          want = 1'b1;
          if (usedw >= FULL_MARK) begin
            word         = {1'b1, 1'b1, gmii_rxd};
            state_d      = DROP;
            trunc_flag_d = 1'b1;
            trunc_d      = trunc_q + 16'd1;
          end else begin
            word = {1'b1, gmii_rx_er, gmii_rxd};
          end
        end else begin
          // The dv-fall cycle carries the first gap word, so the counter holds the remainder.
          state_d   = IFG;
          ifg_cnt_d = IFG_MIN - 4'd1;
          want      = 1'b1;
        end
      end
      DROP: begin
        if (gmii_rx_dv) begin
          want = idle_ok;
        end else if (trunc_flag_q) begin
          state_d   = IFG;
          ifg_cnt_d = IFG_MIN - 4'd1;
          want      = 1'b1;
        end else begin
          state_d = IDLE;
          want    = idle_ok;
        end
      end
      default: state_d = IDLE;
    endcase
    wrreq_d = want & (usedw < GUARD_LVL);
    data_d  = wrreq_d ? word : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      // Treat dv as already high so a frame in progress at release is skipped.
      dv_prev_q    <= 1'b1;
      ifg_cnt_q    <= '0;
      trunc_flag_q <= 1'b0;
      wrreq_q      <= 1'b0;
      data_q       <= '0;
      drop_q       <= '0;
      trunc_q      <= '0;
    end else begin
      state_q      <= state_d;
      dv_prev_q    <= gmii_rx_dv;
      ifg_cnt_q    <= ifg_cnt_d;
      trunc_flag_q <= trunc_flag_d;
      wrreq_q      <= wrreq_d;
      data_q       <= data_d;
      drop_q       <= drop_d;
      trunc_q      <= trunc_d;
    end
  end

  assign wrreq       = wrreq_q;
  assign FIFO_wrdata = data_q;
  assign drop_cnt    = drop_q;
  assign trunc_cnt   = trunc_q;

endmodule

// File: tb/tb_gmii_fifo_writer.sv
// Directed and randomized bench for gmii_fifo_writer; expectations come from a
// frame-level scan of each stimulus segment.
module tb_gmii_fifo_writer;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gmii_rx_dv = 1'b0;
  logic       gmii_rx_er = 1'b0;
  logic [7:0] gmii_rxd = '0;
  logic [7:0] usedw = '0;
  logic       wrreq;
  logic [9:0] FIFO_wrdata;
  logic [15:0] drop_cnt, trunc_cnt;

  int vectors = 0;
  int miscompares = 0;

  gmii_fifo_writer #(.DATA_WIDTH(8), .START_MAX(8'd200), .FULL_MARK(8'd252),
                     .MIN_FILL(8'd4), .IFG_MIN(4'd12)) dut (
    .clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .gmii_rxd(gmii_rxd), .usedw(usedw), .wrreq(wrreq), .FIFO_wrdata(FIFO_wrdata),
    .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt));

  always #5 clk = ~clk;

  // Stimulus segment and its expected output stream.
  logic       s_dv [MAXC];
  logic       s_er [MAXC];
  logic [7:0] s_d  [MAXC];
  logic [7:0] s_uw [MAXC];
  logic       e_wr [MAXC];
  logic [9:0] e_wd [MAXC];
  int         n = 0;
  int         m_drop, m_trunc;

  task automatic clear_seg();
    n = 0;
  endtask

  task automatic push(input logic dv, input logic er, input logic [7:0] d, input logic [7:0] uw);
    if (n < MAXC) begin
      s_dv[n] = dv; s_er[n] = er; s_d[n] = d; s_uw[n] = uw;
      n++;
    end
  endtask

  task automatic add_idle(input int len, input int uw);
    for (int i = 0; i < len; i++) push(1'b0, 1'($urandom), 8'($urandom), 8'(uw));
  endtask

  // Frame of len bytes: usedw is start_uw on byte 0, mid_uw after, cut_uw from byte cut_at on.
  task automatic add_frame(input int len, input int start_uw, input int mid_uw,
                           input int cut_at, input int cut_uw);
    int uw;
    for (int k = 0; k < len; k++) begin
      uw = (k == 0) ? start_uw : ((cut_at >= 0 && k >= cut_at) ? cut_uw : mid_uw);
      push(1'b1, ($urandom_range(0, 7) == 0), 8'($urandom), 8'(uw));
    end
  endtask

  // Class per cycle: 0 idle-on-low-fill, 1 forced gap word, 2 data word.
  task automatic run_model();
    int cls [MAXC];
    logic [9:0] word [MAXC];
    int e;
    bit cut;
    m_drop = 0; m_trunc = 0;
    for (int c = 0; c < n; c++) begin cls[c] = 0; word[c] = '0; end
    for (int c = 0; c < n; c++) begin
      if (s_dv[c] && c > 0 && !s_dv[c-1]) begin
        e = c;
        while (e < n && s_dv[e]) e++;
        if (s_uw[c] > 8'd200) begin
          m_drop++;
        end else begin
          cut = 0;
          for (int k = c; k < e; k++) begin
            if (!cut) begin
              cls[k] = 2;
              if (s_uw[k] >= 8'd252) begin
                word[k] = {2'b11, s_d[k]};
                m_trunc++;
                cut = 1;
              end else begin
                word[k] = {1'b1, s_er[k], s_d[k]};
              end
            end
          end
          for (int g = 0; g < 12 && e + g < n; g++) begin
            if (g > 0 && s_dv[e+g] && !s_dv[e+g-1]) break;
            cls[e+g] = 1;
          end
        end
      end
    end
    for (int c = 0; c < n; c++) begin
      e_wr[c] = ((cls[c] != 0) || (s_uw[c] < 8'd4)) && (s_uw[c] < 8'd254);
      e_wd[c] = (e_wr[c] && cls[c] == 2) ? word[c] : 10'd0;
    end
  endtask

  task automatic check_counters(input string tag);
    vectors++;
    assert (drop_cnt === 16'(m_drop)) else begin
      miscompares++;
      $error("FAIL %s drop_cnt observed=%0d expected=%0d", tag, drop_cnt, m_drop);
    end
    vectors++;
    assert (trunc_cnt === 16'(m_trunc)) else begin
      miscompares++;
      $error("FAIL %s trunc_cnt observed=%0d expected=%0d", tag, trunc_cnt, m_trunc);
    end
  endtask

  task automatic run_seg(input string tag);
    run_model();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      gmii_rx_dv = s_dv[c]; gmii_rx_er = s_er[c]; gmii_rxd = s_d[c]; usedw = s_uw[c];
      @(posedge clk);
      #1;
      vectors++;
      assert ({wrreq, FIFO_wrdata} === {e_wr[c], e_wd[c]}) else begin
        miscompares++;
        $error("FAIL %s cyc %0d observed wr=%b word=%h expected wr=%b word=%h",
               tag, c, wrreq, FIFO_wrdata, e_wr[c], e_wd[c]);
      end
    end
    check_counters(tag);
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    assert ({wrreq, FIFO_wrdata, drop_cnt, trunc_cnt} === 43'd0) else begin
      miscompares++;
      $error("FAIL %s outputs in reset observed wr=%b word=%h drop=%0d trunc=%0d expected all 0",
             tag, wrreq, FIFO_wrdata, drop_cnt, trunc_cnt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    gmii_rx_dv = 1'b0; usedw = 8'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int pick_uw();
    case ($urandom_range(0, 5))
      0, 1:    return $urandom_range(0, 3);
      2, 3:    return $urandom_range(4, 200);
      4:       return $urandom_range(201, 253);
      default: return $urandom_range(254, 255);
    endcase
  endfunction

  initial begin
    do_reset();

    // Plain 64-byte frame at empty FIFO, then gap and low-fill idle.
    clear_seg(); add_idle(4, 0); add_frame(64, 0, 0, -1, 0);
    add_idle(12, 0); add_idle(6, 3); add_idle(6, 4); add_idle(4, 0);
    run_seg("pass64");

    // Fill above START_MAX: whole frame dropped, no gap words.
    do_reset();
    clear_seg(); add_idle(4, 201); add_frame(40, 201, 201, -1, 0); add_idle(20, 201);
    run_seg("drop");

    // Truncation at byte 30.
    do_reset();
    clear_seg(); add_idle(4, 100); add_frame(50, 100, 100, 30, 252); add_idle(20, 100);
    run_seg("trunc");

    // Back-to-back frames with a 5-clock gap.
    do_reset();
    clear_seg(); add_idle(3, 10); add_frame(30, 10, 10, -1, 0); add_idle(5, 10);
    add_frame(30, 10, 10, -1, 0); add_idle(16, 10);
    run_seg("b2b");

    // Guard level during the gap; counter must still expire back to idle.
    do_reset();
    clear_seg(); add_idle(3, 10); add_frame(20, 10, 10, -1, 0); add_idle(12, 254);
    add_idle(10, 100); add_idle(3, 255); add_idle(4, 0);
    run_seg("guard");

    // Reset pulsed mid-frame at byte 20.
    do_reset();
    clear_seg(); add_idle(4, 10); add_frame(20, 10, 10, -1, 0);
    run_seg("rst_pre");
    @(negedge clk);
    gmii_rx_dv = 1'b1; gmii_rxd = 8'h5A; usedw = 8'd10;
    #2 rst = 1'b1;
    #1 check_zero("rst_mid");
    @(posedge clk);
    #1 check_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    clear_seg(); add_frame(43, 0, 0, -1, 0); add_idle(20, 10);
    add_frame(40, 10, 10, -1, 0); add_idle(15, 0);
    run_seg("rst_post");

    // Randomized segments.
    for (int s = 0; s < 8; s++) begin
      do_reset();
      clear_seg();
      for (int f = 0; f < 8; f++) begin
        add_idle($urandom_range(1, 20), pick_uw());
        add_frame($urandom_range(1, 80), pick_uw(), $urandom_range(0, 251),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : -1,
                  $urandom_range(252, 255));
      end
      add_idle(20, pick_uw());
      run_seg("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
